write_output: RTL

WRITE_OUTPUT -- requirements
Module: write_output

---
 rtl/write_output_pkg.sv | 21 ++
 rtl/write_output_interleave_buffer.sv | 47 ++++
 rtl/write_output.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/write_output_pkg.sv
// Shared defaults, state encoding and sizing helper for the write_output batch serializer.
package write_output_pkg;

    localparam int unsigned WORDSIZE_DEF     = 16;
    localparam int unsigned NUMSAMPLES_DEF   = 32;
    localparam int unsigned TOTALSAMPLES_DEF = 96;
    localparam int unsigned NUM_PORTS        = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DRAIN   = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/write_output_interleave_buffer.sv
// Sample buffer: four write ports at stride NUMSAMPLES/4 sharing one write index, one async read port.
module interleave_buffer
    import write_output_pkg::*;
#(
    parameter int unsigned WORDSIZE   = WORDSIZE_DEF,
    parameter int unsigned NUMSAMPLES = NUMSAMPLES_DEF,
    localparam int unsigned STRIDE    = NUMSAMPLES / NUM_PORTS,
    localparam int unsigned AW        = clog2_min1(NUMSAMPLES),
    localparam int unsigned IW        = clog2_min1(STRIDE)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IW-1:0]       waddr,
    input  logic [WORDSIZE-1:0] wdata0,
    input  logic [WORDSIZE-1:0] wdata1,
    input  logic [WORDSIZE-1:0] wdata2,
    input  logic [WORDSIZE-1:0] wdata3,
    input  logic [AW-1:0]       raddr,
    output logic [WORDSIZE-1:0] rdata_c
);

    logic [WORDSIZE-1:0] mem_q   [NUMSAMPLES];
    logic [WORDSIZE-1:0] mem_d   [NUMSAMPLES];
    logic [WORDSIZE-1:0] wdata_c [NUM_PORTS];

    assign wdata_c[0] = wdata0;
    assign wdata_c[1] = wdata1;
    assign wdata_c[2] = wdata2;
    assign wdata_c[3] = wdata3;

    // Port n lands at waddr + n*STRIDE, so one beat fills one column of the buffer.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int n = 0; n < int'(NUM_PORTS); n++) begin
                mem_d[AW'(n * int'(STRIDE)) + AW'(waddr)] = wdata_c[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/write_output.sv
// Collects interleaved 4-word beats into a batch buffer, then serializes it with valid/ready,
// repeating for TOTALSAMPLES/NUMSAMPLES batches per start.
module write_output
    import write_output_pkg::*;
#(
    parameter int unsigned WORDSIZE     = WORDSIZE_DEF,
    parameter int unsigned NUMSAMPLES   = NUMSAMPLES_DEF,
    parameter int unsigned TOTALSAMPLES = TOTALSAMPLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] data_in0,
    input  logic [WORDSIZE-1:0] data_in1,
    input  logic [WORDSIZE-1:0] data_in2,
    input  logic [WORDSIZE-1:0] data_in3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] data_out,
    output logic                done,
    output logic                error
);

    localparam int unsigned BEATS  = NUMSAMPLES / NUM_PORTS;
    localparam int unsigned NBATCH = TOTALSAMPLES / NUMSAMPLES;
    localparam int unsigned IW     = clog2_min1(BEATS);
    localparam int unsigned KW     = clog2_min1(NUMSAMPLES);
    localparam int unsigned BW     = clog2_min1(NBATCH + 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [KW-1:0]       k_q, k_d;
    logic [BW-1:0]       batch_q, batch_d;
    logic                error_q, error_d;
    logic                done_q, done_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [WORDSIZE-1:0] data_out_q, data_out_d;
    logic                buf_we_c;
    logic [WORDSIZE-1:0] rdata_c;

    interleave_buffer #(
        .WORDSIZE   (WORDSIZE),
        .NUMSAMPLES (NUMSAMPLES)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we_c),
        .waddr   (i_q),
        .wdata0  (data_in0),
        .wdata1  (data_in1),
        .wdata2  (data_in2),
        .wdata3  (data_in3),
        .raddr   (k_d),
        .rdata_c (rdata_c)
    );

    // Next state, counters and sticky error; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        k_d         = k_q;
        batch_d     = batch_q;
        error_d     = error_q;
        buf_we_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                batch_d = '0;
                if (s) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (in_valid) begin
                    buf_we_c = 1'b1;
                    if (i_q == IW'(BEATS - 1)) begin
                        i_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (in_valid) error_d = 1'b1;
                if (out_ready) begin
                    if (k_q == KW'(NUMSAMPLES - 1)) begin
                        k_d     = '0;
                        batch_d = batch_q + BW'(1);
                        state_d = (batch_q + BW'(1) == BW'(NBATCH)) ? ST_DONE : ST_COLLECT;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    error_d = 1'b0;
                    batch_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_COLLECT);
        out_valid_d = (state_d == ST_DRAIN);
        done_d      = (state_d == ST_DONE);
        data_out_d  = '0;
        if (state_d == ST_DRAIN) begin
            data_out_d = rdata_c;
            // Word 0 is still in flight when a batch is a single beat deep.
            if (buf_we_c && i_q == '0) data_out_d = data_in0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            k_q         <= '0;
            batch_q     <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            k_q         <= k_d;
            batch_q     <= batch_d;
            error_q     <= error_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
